// File: rtl/candidate_generator.sv
// Shortlex lowercase candidate source: bijective odometer with start offset and stride.
// Optional feature macro: CANDGEN_COUNT_EN adds the cand_count take counter output.
`timescale 1ns/1ps
module candidate_generator #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] CHARSET_BASE = 8'h61,
    parameter int         CHARSET_SIZE = 26
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic [0:7]   startingPosition,
    input  logic [2:0]   increment,
    input  logic         ready,
    output logic [0:127] guess,
    output logic [0:7]   numCharacters,
    output logic         guess_valid,
    output logic         done
`ifdef CANDGEN_COUNT_EN
    ,
    output logic [0:31]  cand_count
`endif
);

    localparam int         DW    = 7;
    localparam logic [7:0] SIZE8 = 8'(CHARSET_SIZE);

    typedef enum logic [1:0] {ST_SKIP, ST_OFFER, ST_DONE} state_t;

    state_t          state_reg;
    logic [DW-1:0]   digits_reg  [MAX_LEN];
    logic [DW-1:0]   digits_next [MAX_LEN];
    logic [MAX_LEN:1] carry;
    logic [7:0]      skip_reg;
    logic [2:0]      stride_reg;
    logic [2:0]      add_k;
    logic [0:127]    guess_next;
    logic [7:0]      len_next;

    assign add_k = (state_reg == ST_SKIP) ? 3'd1 : stride_reg;

    // Ripple adder: stride enters digit 0, each higher digit absorbs at most one carry.
    // An absent digit (0) that receives a carry becomes 1, growing the length.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_digit
            logic [7:0] raw;
            if (gi == 0) begin : g_lsd
                assign raw = {1'b0, digits_reg[gi]} + {5'd0, add_k};
            end else begin : g_upper
                assign raw = {1'b0, digits_reg[gi]} + {7'd0, carry[gi]};
            end
            assign carry[gi+1]     = (raw > SIZE8);
            assign digits_next[gi] = carry[gi+1] ? DW'(raw - SIZE8) : raw[DW-1:0];
        end
    endgenerate

    // Most significant digit is the first character, left-justified in guess.
    always_comb begin
        len_next = 8'd1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (digits_next[i] != '0) begin
                len_next = 8'(i + 1);
            end
        end
        guess_next = '0;
        for (int j = 0; j < MAX_LEN; j++) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i + j + 1 == int'(len_next)) begin
                    guess_next[8*j +: 8] = CHARSET_BASE + {1'b0, digits_next[i]} - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_SKIP;
            for (int i = 0; i < MAX_LEN; i++) begin
                digits_reg[i] <= '0;
            end
            digits_reg[0] <= DW'(1);
            skip_reg      <= startingPosition;
            stride_reg    <= (increment == 3'd0) ? 3'd1 : increment;
            guess         <= {CHARSET_BASE, 120'd0};
            numCharacters <= 8'd1;
            guess_valid   <= 1'b0;
            done          <= 1'b0;
`ifdef CANDGEN_COUNT_EN
            cand_count    <= '0;
`endif
        end else if (enable) begin
            case (state_reg)
                ST_SKIP: begin
                    if (skip_reg == 8'd0) begin
                        state_reg   <= ST_OFFER;
                        guess_valid <= 1'b1;
                    end else if (carry[MAX_LEN]) begin
                        // Offset already beyond the keyspace: nothing to offer.
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                    end else begin
                        digits_reg    <= digits_next;
                        guess         <= guess_next;
                        numCharacters <= len_next;
                        skip_reg      <= skip_reg - 8'd1;
                    end
                end
                ST_OFFER: begin
                    if (ready && guess_valid) begin
                        if (carry[MAX_LEN]) begin
                            state_reg   <= ST_DONE;
                            guess_valid <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            digits_reg    <= digits_next;
                            guess         <= guess_next;
                            numCharacters <= len_next;
                        end
`ifdef CANDGEN_COUNT_EN
                        if (cand_count != '1) begin
                            cand_count <= cand_count + 32'd1;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_candidate_generator.sv
// Scoreboard bench for candidate_generator: shortlex index model feeds a queue, a monitor checks takes.
`timescale 1ns/1ps
module tb_candidate_generator;

    localparam int     ML    = 3;
    localparam int     CS    = 26;
    localparam longint TOTAL = 26 + 676 + 17576;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         ready = 1'b0;
    logic [0:7]   startingPosition = 8'd0;
    logic [2:0]   increment = 3'd1;
    logic [0:127] guess;
    logic [0:7]   numCharacters;
    logic         guess_valid;
    logic         done;
`ifdef CANDGEN_COUNT_EN
    logic [0:31]  cand_count;
`endif

    candidate_generator #(
        .MAX_LEN(ML),
        .CHARSET_BASE(8'h61),
        .CHARSET_SIZE(CS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .startingPosition(startingPosition),
        .increment(increment),
        .ready(ready),
        .guess(guess),
        .numCharacters(numCharacters),
        .guess_valid(guess_valid),
        .done(done)
`ifdef CANDGEN_COUNT_EN
        ,
        .cand_count(cand_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [0:127] g;
        logic [7:0]   n;
        bit           last;
    } item_t;

    item_t sb[$];
    item_t mon_e;
    item_t final_item;
    int    vectors = 0;
    int    miscompares = 0;
    bit    pending = 1'b0;
    int    take_cnt = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Candidate index -> string by bijective base-CS conversion.
    function automatic item_t model(longint idx, bit last);
        item_t      r;
        longint     v;
        int         l;
        logic [7:0] ch [16];
        v = idx + 1;
        l = 0;
        r.g = '0;
        while (v > 0 && l < 16) begin
            v = v - 1;
            ch[l] = 8'h61 + 8'(v % CS);
            v = v / CS;
            l++;
        end
        for (int j = 0; j < l; j++) begin
            r.g[8*j +: 8] = ch[l-1-j];
        end
        r.n = 8'(l);
        r.last = last;
        return r;
    endfunction

    // Monitor: every take must match the head of the expected queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (pending) begin
                check("done_after_last", 128'(done), 128'd1);
                check("valid_after_last", 128'(guess_valid), 128'd0);
                pending = 1'b0;
            end
            if (enable && ready && guess_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_take: got a take with guess %h, required no take", guess);
                end else begin
                    mon_e = sb.pop_front();
                    check("guess", 128'(guess), 128'(mon_e.g));
                    check("num_chars", 128'(numCharacters), 128'(mon_e.n));
                    check("done_low", 128'(done), 128'd0);
`ifdef CANDGEN_COUNT_EN
                    check("cand_count", 128'(cand_count), 128'(take_cnt));
`endif
                    take_cnt++;
                    if (mon_e.last) pending = 1'b1;
                end
            end
        end
    end

    task automatic run(int start, int stride, int n_items, int rp, int ep, int stall, string tag);
        int           s;
        longint       idx;
        int           edges;
        int           cycles;
        int           bound;
        bit           found;
        bit           exhausted;
        bit           lst;
        int           pushed;
        logic [0:127] reset_guess;
        s = (stride == 0) ? 1 : stride;
        reset_guess = {8'h61, 120'd0};
        @(posedge clock); #1;
        reset = 1'b1;
        enable = 1'b1;
        ready = 1'($urandom_range(0, 1));
        startingPosition = 8'(start);
        increment = 3'(stride);
        sb.delete();
        pending = 1'b0;
        take_cnt = 0;
        @(posedge clock); #1;
        check("reset_guess", 128'(guess), 128'(reset_guess));
        check("reset_num", 128'(numCharacters), 128'd1);
        check("reset_valid", 128'(guess_valid), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        exhausted = 1'b0;
        pushed = 0;
        idx = longint'(start);
        while (pushed < n_items && idx < TOTAL) begin
            lst = (idx + s >= TOTAL);
            final_item = model(idx, lst);
            sb.push_back(final_item);
            if (lst) exhausted = 1'b1;
            idx += s;
            pushed++;
        end
        reset = 1'b0;

        edges = 0;
        found = 1'b0;
        while (!found && edges < 400) begin
            enable = (edges >= 3 && edges < 3 + stall) ? 1'b0 : 1'b1;
            ready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            edges++;
            if (guess_valid) found = 1'b1;
        end
        check("first_valid_edge", 128'(edges), 128'(start + 1 + stall));

        cycles = 0;
        bound = 10 * pushed + 200;
        while (sb.size() > 0 && cycles < bound) begin
            ready = ($urandom_range(0, 99) < rp);
            enable = ($urandom_range(0, 99) < ep);
            @(posedge clock); #1;
            cycles++;
        end
        check("queue_drained", 128'(sb.size()), 128'd0);

        if (exhausted) begin
            for (int k = 0; k < 3; k++) begin
                ready = 1'b1;
                enable = 1'b1;
                @(posedge clock); #1;
                check("done_sticky", 128'(done), 128'd1);
                check("done_valid_low", 128'(guess_valid), 128'd0);
                check("done_guess_held", 128'(guess), 128'(final_item.g));
            end
        end else begin
            ready = 1'b0;
            @(posedge clock); #1;
            check("not_done", 128'(done), 128'd0);
        end
        ready = 1'b0;
        $display("run %s: start=%0d stride=%0d takes=%0d exhausted=%0d", tag, start, stride, take_cnt, exhausted);
    endtask

    initial begin
        run(0, 1, 40, 100, 100, 0, "a_through_an");
        run(25, 1, 10, 50, 100, 0, "start_z");
        run(24, 3, 10, 70, 100, 0, "stride3");
        run(10, 2, 20, 60, 80, 3, "skip_stall");
        run(2, 0, 15, 60, 90, 0, "stride0_after_offer");
        run(0, 1, 100000, 100, 100, 0, "exhaust_stride1");
        run(int'($urandom_range(0, 255)), 7, 100000, 80, 90, 0, "exhaust_stride7");
        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 150, 60, 80, 0, "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no completion by 5ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/candidate_generator.md
# candidate_generator

Plaintext candidate source feeding the MD5 cracking datapath: the producer side of the controller's `ready`/`guess`/`numCharacters` handshake. It enumerates lowercase strings in shortlex order ("a".."z", "aa".."zz", ...) as a bijective base-`CHARSET_SIZE` odometer. Each enumeration starts at offset `startingPosition` and advances by stride `increment`, so parallel cores can interleave the keyspace. It presents one left-justified 128-bit candidate at a time and advances only when the consumer takes it.

## Interface
- `MAX_LEN`, 16: maximum candidate length in characters, 1..16.
- `CHARSET_BASE`, 8'h61: ASCII code of digit value 1 ('a').
- `CHARSET_SIZE`, 26: symbols per position, 8..94 (must exceed 7).

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `enable`  in  1  global run; low freezes all state.
- `startingPosition`  in  [0:7]  initial candidate index (0 = "a"); sampled while `reset` high.
- `increment`  in  [2:0]  stride; sampled while `reset` high; 0 treated as 1.
- `ready`  in  1  consumer take strobe.
- `guess`  out  [0:127]  candidate; first character in `guess[0:7]`, unused bytes 0.
- `numCharacters`  out  [0:7]  candidate length in characters, 1..`MAX_LEN`.
- `guess_valid`  out  1  `guess`/`numCharacters` hold a deliverable candidate.
- `done`  out  1  keyspace exhausted; sticky until reset.

## Operation
- State: `MAX_LEN` digit registers, each 0..`CHARSET_SIZE` (0 = absent, d>0 = character `CHARSET_BASE`+d-1). Also an 8-bit skip counter, a latched stride, and FSM {SKIP, OFFER, DONE}.
- Reset: digit0=1, others 0; skip counter ← `startingPosition`; stride ← `increment` (0→1); state SKIP.
- Reset values: `guess`={8'h61,120'h0}, `numCharacters`=1, `guess_valid`=0, `done`=0.
- Addition of k:
  - digit0 += k.
  - For each digit i, if value > `CHARSET_SIZE`, subtract `CHARSET_SIZE` and carry 1 into digit i+1.
  - A carry into an absent digit makes it 1, so length grows by one.
  - At most one carry per digit per step.
- SKIP:
  - If skip counter ≠ 0: add 1 and decrement the counter.
  - Else: go to OFFER and set `guess_valid`=1.
- OFFER, take = `enable` & `ready` & `guess_valid`:
  - On take, add the stride at that edge. The next candidate appears on the following cycle with `guess_valid` still 1, so full throughput is 1 candidate/cycle.
  - If the addition carries out of digit `MAX_LEN`-1, go to DONE, clear `guess_valid`, set `done`=1, and leave digits unchanged.
- DONE: all inputs except `reset` are ignored.
- `ready` while `guess_valid`=0 is ignored (no pending request is stored).
- Consumer rule: assert `ready` only in cycles where it latches `guess`. Holding `ready` high while not latching discards candidates.
- `enable` low: no skip, no advance, outputs hold.
- Reset mid-operation (any state) restarts from the newly sampled `startingPosition`/`increment` on the next edge.
- `numCharacters` = index of the highest non-zero digit + 1. `guess` byte j (bits [8j:8j+7]) = character of digit `numCharacters`-1-j for j < `numCharacters`, else 0.

## Timing
- `guess`, `numCharacters`, `guess_valid` and `done` are registered; there is no combinational path from `ready` to any output.
- After `reset` deasserts, `guess_valid` rises on edge `startingPosition`+1 (edge 1 for position 0), assuming `enable` is high throughout.
- Take-to-next-candidate latency: 1 cycle.
- The `done` assertion edge is the take edge of the last candidate.
- Skip and advance each cost one edge only when `enable` is high.

## Configuration
- `CANDGEN_COUNT_EN` defined:
  - Adds output `cand_count` [0:31], reset 0.
  - Increments on each take; saturates at 32'hFFFFFFFF.
  - Held in DONE.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- start 0, stride 1, `ready` held 1 → `guess_valid` at edge 1 with "a" (8'h61, len 1); takes yield "b".."z"; 27th candidate "aa" (16'h6161, len 2).
- start 25, stride 1 → first valid "z" at edge 26; one take → "aa"; `ready` low for 5 cycles → "aa" held.
- start 24, stride 3 → "y"; take → "ab"; take → "ae".
- `MAX_LEN`=2, start 0, stride 1, continuous take → 702nd candidate "zz"; its take sets `done`=1 and `guess_valid`=0 next cycle; further `ready` → no change.
- `enable` low mid-SKIP (start 10) delays `guess_valid` one cycle per low cycle. `reset` pulsed in OFFER with start 2 → "c" at edge 3.
- With `CANDGEN_COUNT_EN`: 5 takes → `cand_count`=5; `ready` without `guess_valid` → no increment.
